// File: rtl/alnpc_ram_pkg.sv
// Shared types and priority-select helper for the multi-port ALNPC RAM.
// Build option: ALNPC_RAM_BYPASS_EN enables same-cycle write-to-read forwarding.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif

package alnpc_ram_pkg;

   typedef enum logic {CLEAR, READY} alnpc_ram_state_t;

   // prio_sel works on fixed maximum widths; callers zero-pad their port vectors.
   localparam int unsigned PS_MAX_PORTS = 16;
   localparam int unsigned PS_MAX_INDEX = 16;
   localparam int unsigned PS_SEL_W     = 4;

   typedef struct packed {
      logic                hit;
      logic [PS_SEL_W-1:0] idx;
   } prio_t;

   // Highest-numbered enabled port whose address equals target wins.
   function automatic prio_t prio_sel(input logic [PS_MAX_PORTS-1:0]              we,
                                      input logic [PS_MAX_PORTS*PS_MAX_INDEX-1:0] addr,
                                      input logic [PS_MAX_INDEX-1:0]              target);
      prio_t r;
      r = '0;
      for (int unsigned p = 0; p < PS_MAX_PORTS; p++) begin
         if (we[p] && (addr[p*PS_MAX_INDEX +: PS_MAX_INDEX] == target)) begin
            r.hit = 1'b1;
            r.idx = PS_SEL_W'(p);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/alnpc_ram_wr_arb.sv
// Per-entry write arbitration: resolves all write ports into one enable/data per entry
// (highest port wins) and flags same-address collisions among in-range writes.
module alnpc_ram_wr_arb
   import alnpc_ram_pkg::*;
#(
   parameter int unsigned WPORT = 4,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned INDEX = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   en,
   input  logic [WPORT-1:0]       we,
   input  logic [WPORT*INDEX-1:0] waddr,
   input  logic [WPORT*WIDTH-1:0] wdata,
   output logic [DEPTH-1:0]       ent_we,
   output logic [DEPTH*WIDTH-1:0] ent_data,
   output logic                   conflict
);

   logic [PS_MAX_PORTS-1:0]              we_pad;
   logic [PS_MAX_PORTS*PS_MAX_INDEX-1:0] addr_pad;

   always_comb begin
      we_pad   = '0;
      addr_pad = '0;
      for (int unsigned p = 0; p < WPORT; p++) begin
         we_pad[p] = we[p];
         addr_pad[p*PS_MAX_INDEX +: PS_MAX_INDEX] = PS_MAX_INDEX'(waddr[p*INDEX +: INDEX]);
      end
   end

   always_comb begin
      prio_t sel;
      sel      = '0;
      ent_we   = '0;
      ent_data = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         sel = prio_sel(we_pad, addr_pad, PS_MAX_INDEX'(e));
         ent_we[e] = en && sel.hit;
         ent_data[e*WIDTH +: WIDTH] = wdata[sel.idx*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int unsigned i = 0; i < WPORT; i++) begin
         for (int unsigned j = i + 1; j < WPORT; j++) begin
            if (we[i] && we[j] &&
                (waddr[i*INDEX +: INDEX] == waddr[j*INDEX +: INDEX]) &&
                (32'(waddr[i*INDEX +: INDEX]) < DEPTH))
               conflict = 1'b1;
         end
      end
      conflict = conflict && en;
   end

endmodule

// File: rtl/alnpc_ram_mp.sv
// Multi-port ALNPC RAM: async reads, prioritised sync writes, built-in clear sweep.
// Build option: ALNPC_RAM_BYPASS_EN forwards same-cycle writes to matching reads.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif

module alnpc_ram_mp
   import alnpc_ram_pkg::*;
#(
   parameter int unsigned     RPORT     = 1,
   parameter int unsigned     WPORT     = `ISSUE_WIDTH,
   parameter int unsigned     DEPTH     = 16,
   parameter int unsigned     INDEX     = 4,
   parameter int unsigned     WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush_i,
   output logic                   ready_o,
   input  logic [RPORT*INDEX-1:0] raddr_i,
   output logic [RPORT*WIDTH-1:0] rdata_o,
   input  logic [WPORT*INDEX-1:0] waddr_i,
   input  logic [WPORT*WIDTH-1:0] wdata_i,
   input  logic [WPORT-1:0]       we_i,
   output logic                   wr_conflict_o
);

   alnpc_ram_state_t state, state_nxt;
   logic [INDEX-1:0] clr_ptr, clr_ptr_nxt;
   logic             wr_en;
   logic             conflict;
   logic [DEPTH-1:0]       ent_we;
   logic [DEPTH*WIDTH-1:0] ent_data;
   logic [WIDTH-1:0]       ram [DEPTH];

   always_comb wr_en = (state == READY) && !flush_i && !reset;

   alnpc_ram_wr_arb #(
      .WPORT (WPORT),
      .DEPTH (DEPTH),
      .INDEX (INDEX),
      .WIDTH (WIDTH)
   ) u_wr_arb (
      .en       (wr_en),
      .we       (we_i),
      .waddr    (waddr_i),
      .wdata    (wdata_i),
      .ent_we   (ent_we),
      .ent_data (ent_data),
      .conflict (conflict)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= CLEAR;
         clr_ptr       <= '0;
         wr_conflict_o <= 1'b0;
      end else begin
         state         <= state_nxt;
         clr_ptr       <= clr_ptr_nxt;
         wr_conflict_o <= conflict;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      if (flush_i) begin
         state_nxt   = CLEAR;
         clr_ptr_nxt = '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr_nxt = clr_ptr + 1'b1;
               if (clr_ptr == INDEX'(DEPTH - 1)) begin
                  state_nxt   = READY;
                  clr_ptr_nxt = '0;
               end
            end
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
         endcase
      end
   end

   always_comb ready_o = (state == READY);

   // Sweep write and port writes never coincide: ent_we is only live in READY.
   always_ff @(posedge clk) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
         if (!reset && !flush_i && (state == CLEAR) && (clr_ptr == INDEX'(e)))
            ram[e] <= RESET_VAL;
         else if (ent_we[e])
            ram[e] <= ent_data[e*WIDTH +: WIDTH];
      end
   end

`ifdef ALNPC_RAM_BYPASS_EN
   logic [PS_MAX_PORTS-1:0]              we_pad;
   logic [PS_MAX_PORTS*PS_MAX_INDEX-1:0] addr_pad;

   always_comb begin
      we_pad   = '0;
      addr_pad = '0;
      for (int unsigned p = 0; p < WPORT; p++) begin
         we_pad[p] = we_i[p];
         addr_pad[p*PS_MAX_INDEX +: PS_MAX_INDEX] = PS_MAX_INDEX'(waddr_i[p*INDEX +: INDEX]);
      end
   end
`endif

   always_comb begin
      logic [INDEX-1:0] ra;
      logic [WIDTH-1:0] val;
`ifdef ALNPC_RAM_BYPASS_EN
      prio_t bp;
      bp = '0;
`endif
      ra      = '0;
      val     = RESET_VAL;
      rdata_o = '0;
      for (int unsigned p = 0; p < RPORT; p++) begin
         ra  = raddr_i[p*INDEX +: INDEX];
         val = RESET_VAL;
         if (ready_o && (32'(ra) < DEPTH)) begin
            val = ram[ra];
`ifdef ALNPC_RAM_BYPASS_EN
            bp = prio_sel(we_pad, addr_pad, PS_MAX_INDEX'(ra));
            if (wr_en && bp.hit)
               val = wdata_i[bp.idx*WIDTH +: WIDTH];
`endif
         end
         rdata_o[p*WIDTH +: WIDTH] = val;
      end
   end

endmodule

// File: tb/tb_alnpc_ram_mp.sv
// Randomised bench for alnpc_ram_mp: DEPTH=16 and DEPTH=12 instances share stimulus
// and are checked against an array/sweep-countdown model (honours ALNPC_RAM_BYPASS_EN).
module tb_alnpc_ram_mp;

   localparam int NW = 4;
   localparam int NR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic             fl = 1'b0;
   logic [NW-1:0]    we_v = '0;
   logic [NW*4-1:0]  wa_v = '0;
   logic [NW*8-1:0]  wd_v = '0;
   logic [NR*4-1:0]  ra_v = '0;

   logic            rdy16, cf16, rdy12, cf12;
   logic [NR*8-1:0] rd16, rd12;

   alnpc_ram_mp #(.RPORT(NR), .WPORT(NW), .DEPTH(16), .INDEX(4), .WIDTH(8), .RESET_VAL(8'h00)) dut16 (
      .clk(clk), .reset(rst), .flush_i(fl), .ready_o(rdy16),
      .raddr_i(ra_v), .rdata_o(rd16), .waddr_i(wa_v), .wdata_i(wd_v), .we_i(we_v),
      .wr_conflict_o(cf16));

   alnpc_ram_mp #(.RPORT(NR), .WPORT(NW), .DEPTH(12), .INDEX(4), .WIDTH(8), .RESET_VAL(8'h00)) dut12 (
      .clk(clk), .reset(rst), .flush_i(fl), .ready_o(rdy12),
      .raddr_i(ra_v), .rdata_o(rd12), .waddr_i(wa_v), .wdata_i(wd_v), .we_i(we_v),
      .wr_conflict_o(cf12));

   int total = 0;
   int bad   = 0;

   // Model: contents plus number of sweep cycles still owed before the RAM is usable.
   int mem [2][16];
   int sweep [2];
   int conf_exp [2];
   int dep [2] = '{16, 12};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic int exp_rd(input int d, input int a);
      int v;
      if (sweep[d] != 0) return 0;
      if (a >= dep[d]) return 0;
      v = mem[d][a];
`ifdef ALNPC_RAM_BYPASS_EN
      if (!rst && !fl)
         for (int p = 0; p < NW; p++)
            if (we_v[p] && int'(wa_v[p*4 +: 4]) == a) v = int'(wd_v[p*8 +: 8]);
`endif
      return v;
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (rst || fl) begin
            sweep[d] = dep[d];
            conf_exp[d] = 0;
            for (int a = 0; a < 16; a++) mem[d][a] = 0;
         end else if (sweep[d] != 0) begin
            sweep[d]--;
            conf_exp[d] = 0;
         end else begin
            conf_exp[d] = 0;
            for (int i = 0; i < NW; i++)
               for (int j = i + 1; j < NW; j++)
                  if (we_v[i] && we_v[j] && wa_v[i*4 +: 4] == wa_v[j*4 +: 4] &&
                      int'(wa_v[i*4 +: 4]) < dep[d])
                     conf_exp[d] = 1;
            for (int p = 0; p < NW; p++)
               if (we_v[p] && int'(wa_v[p*4 +: 4]) < dep[d])
                  mem[d][int'(wa_v[p*4 +: 4])] = int'(wd_v[p*8 +: 8]);
         end
      end
   endtask

   task automatic tick(input logic r, input logic f, input logic [NW-1:0] we,
                       input logic [NW*4-1:0] wa, input logic [NW*8-1:0] wd,
                       input logic [NR*4-1:0] ra);
      @(negedge clk);
      rst = r; fl = f; we_v = we; wa_v = wa; wd_v = wd; ra_v = ra;
      #1;
      for (int p = 0; p < NR; p++) begin
         chk("rdata16", 32'(rd16[p*8 +: 8]), 32'(exp_rd(0, int'(ra[p*4 +: 4]))));
         chk("rdata12", 32'(rd12[p*8 +: 8]), 32'(exp_rd(1, int'(ra[p*4 +: 4]))));
      end
      model_edge();
      @(posedge clk);
      #1;
      chk("ready16", 32'(rdy16), 32'(sweep[0] == 0));
      chk("ready12", 32'(rdy12), 32'(sweep[1] == 0));
      chk("conflict16", 32'(cf16), 32'(conf_exp[0]));
      chk("conflict12", 32'(cf12), 32'(conf_exp[1]));
   endtask

   task automatic rnd_tick(input int lo, input int hi, input int we_pct);
      logic [NW-1:0]   we;
      logic [NW*4-1:0] wa;
      logic [NR*4-1:0] ra;
      for (int p = 0; p < NW; p++) begin
         we[p] = ($urandom_range(0, 99) < we_pct);
         wa[p*4 +: 4] = 4'($urandom_range(lo, hi));
      end
      for (int p = 0; p < NR; p++) ra[p*4 +: 4] = 4'($urandom_range(0, 15));
      tick(1'b0, 1'b0, we, wa, NW*8'($urandom()), ra);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         tick(1'b0, 1'b0, '0, NW*4'($urandom()), NW*8'($urandom()), NR*4'($urandom()));
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         sweep[d] = dep[d];
         conf_exp[d] = 0;
         for (int a = 0; a < 16; a++) mem[d][a] = 0;
      end
      repeat (2) @(posedge clk);

      // Reset cycle, then the post-reset sweep with no activity.
      tick(1'b1, 1'b0, '1, '0, '1, '0);
      idle(18);

      // Single write then read-back, including same-cycle read.
      tick(1'b0, 1'b0, 4'b0001, 16'h0003, 32'h0000_00A5, 8'h33);
      tick(1'b0, 1'b0, 4'b0000, 16'h0000, 32'h0000_0000, 8'h03);

      // Ports 0 and 2 collide on address 5; port 2 must win.
      tick(1'b0, 1'b0, 4'b0101, 16'h0505, 32'h0022_0011, 8'h55);
      tick(1'b0, 1'b0, 4'b0000, 16'h0000, 32'h0000_0000, 8'h55);
      tick(1'b0, 1'b0, 4'b0000, 16'h0000, 32'h0000_0000, 8'h05);

      // Fill, flush with every port writing, then scan all entries after the sweep.
      for (int i = 0; i < 24; i++) rnd_tick(0, 15, 100);
      tick(1'b0, 1'b1, '1, NW*4'($urandom()), NW*8'($urandom()), 8'h21);
      idle(17);
      for (int a = 0; a < 16; a++)
         tick(1'b0, 1'b0, '0, '0, '0, {4'(15 - a), 4'(a)});

      // Second flush at cycle 7 of a sweep restarts it.
      for (int i = 0; i < 10; i++) rnd_tick(0, 15, 80);
      tick(1'b0, 1'b1, '0, '0, '0, '0);
      idle(7);
      tick(1'b0, 1'b1, '1, NW*4'($urandom()), NW*8'($urandom()), '0);
      idle(17);

      // Out-of-range address for the 12-entry instance.
      tick(1'b0, 1'b0, 4'b0001, 16'h000E, 32'h0000_0077, 8'hEE);
      tick(1'b0, 1'b0, 4'b0000, 16'h0000, 32'h0000_0000, 8'hE3);

      // Reset in the middle of a sweep.
      tick(1'b0, 1'b1, '0, '0, '0, '0);
      idle(5);
      tick(1'b1, 1'b0, '1, NW*4'($urandom()), NW*8'($urandom()), '0);
      idle(17);

      // Narrow address window forces collisions, some straddling DEPTH=12.
      for (int i = 0; i < 60; i++) rnd_tick(10, 13, 60);
      for (int i = 0; i < 100; i++) rnd_tick(0, 15, 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
